// File: rtl/dec_to_bcd_key_encoder.sv
// Ten-line decimal keypad to BCD encoder: 2-flop sync, debounce FSM with multi-key
// rejection, one-cycle valid/error strobes and a shift-in BCD entry register.
module dec_to_bcd_key_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIGITS          = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [9:0]                     d,
    input  logic                           clr,
    output logic                           key_valid,
    output logic [3:0]                     key_code,
    output logic                           key_err,
    output logic [4*DIGITS-1:0]            digits,
    output logic [$clog2(DIGITS+1)-1:0]    digit_cnt
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW  = $clog2(DIGITS + 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  DIGITS_MAX = CW'(DIGITS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [9:0]           sync1_q, s_q;
    logic [9:0]           pat_q, pat_d;
    logic [DBW-1:0]       cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic [3:0]           code_q, code_d;
    logic [4*DIGITS-1:0]  digits_q, digits_d;
    logic [CW-1:0]        dcnt_q, dcnt_d;

    logic [3:0]           ones;
    logic [3:0]           idx;
    logic                 one_hot;
    logic                 accept;
    logic [4*DIGITS-1:0]  shifted;

    // Bit count and index of the highest set bit of the synced pattern; the index is
    // only used when exactly one bit is set.
    always_comb begin
        ones = 4'd0;
        idx  = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (s_q[i]) begin
                ones = ones + 4'd1;
                idx  = 4'(i);
            end
        end
        one_hot = (ones == 4'd1);
    end

    generate
        if (DIGITS == 1) begin : g_single
            assign shifted = idx;
        end else begin : g_multi
            assign shifted = {digits_q[4*DIGITS-5:0], idx};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_q != 10'd0) begin
                    pat_d   = s_q;
                    cnt_d   = DBW'(1);
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (s_q == pat_q) begin
                    cnt_d = cnt_q + DBW'(1);
                end else if (s_q == 10'd0) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    pat_d = s_q;
                    cnt_d = DBW'(1);
                end
            end
            HELD: begin
                if (s_q == 10'd0) begin
                    if (cnt_q + DBW'(1) == DB_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + DBW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // The sample that completes the stable run is evaluated immediately; s equals
        // the captured pattern here, so the decode of s is the decode of p.
        if (state_d == DEBOUNCE && cnt_d == DB_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            if (one_hot) begin
                valid_d = 1'b1;
                code_d  = idx;
                accept  = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        digits_d = digits_q;
        dcnt_d   = dcnt_q;
        if (clr) begin
            digits_d = '0;
            dcnt_d   = '0;
        end else if (accept) begin
            digits_d = shifted;
            if (dcnt_q != DIGITS_MAX) begin
                dcnt_d = dcnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            s_q      <= '0;
            state_q  <= IDLE;
            pat_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
            digits_q <= '0;
            dcnt_q   <= '0;
        end else begin
            sync1_q  <= d;
            s_q      <= sync1_q;
            state_q  <= state_d;
            pat_q    <= pat_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            code_q   <= code_d;
            digits_q <= digits_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign key_valid = valid_q;
    assign key_err   = err_q;
    assign key_code  = code_q;
    assign digits    = digits_q;
    assign digit_cnt = dcnt_q;

endmodule

// File: tb/tb_dec_to_bcd_key_encoder.sv
// Directed bench for dec_to_bcd_key_encoder at the default parameters.
module tb_dec_to_bcd_key_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  d;
    logic        clr;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_err;
    logic [15:0] digits;
    logic [2:0]  digit_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int vld_total = 0;
    int err_total = 0;
    int both_total = 0;
    int v0, e0;

    dec_to_bcd_key_encoder #(.DEBOUNCE_CYCLES(4), .DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .d         (d),
        .clr       (clr),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_err   (key_err),
        .digits    (digits),
        .digit_cnt (digit_cnt)
    );

    always #5 clk = ~clk;

    // Pulse counters: each counted cycle is one cycle the strobe was high.
    always @(posedge clk) begin
        if (key_valid) vld_total++;
        if (key_err) err_total++;
        if (key_valid && key_err) both_total++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        d   = 10'd0;
        clr = 1'b0;

        // 1: reset values, then idle with no keys
        tick(3);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_err", 32'(key_err), 32'd0);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_cnt", 32'(digit_cnt), 32'd0);
        rst = 1'b0;
        v0 = vld_total;
        e0 = err_total;
        tick(20);
        chk("idle_valid_pulses", 32'(vld_total - v0), 32'd0);
        chk("idle_err_pulses", 32'(err_total - e0), 32'd0);

        // 2: key 3 latency and single pulse on a long hold
        v0 = vld_total;
        d = 10'b00_0000_1000;
        tick(5);
        chk("t2_edge5_valid", 32'(key_valid), 32'd0);
        tick(1);
        chk("t2_edge6_valid", 32'(key_valid), 32'd1);
        chk("t2_code", 32'(key_code), 32'd3);
        chk("t2_digit0", 32'(digits[3:0]), 32'd3);
        chk("t2_cnt", 32'(digit_cnt), 32'd1);
        tick(1);
        chk("t2_edge7_valid", 32'(key_valid), 32'd0);
        tick(3);
        d = 10'd0;
        tick(10);
        chk("t2_pulses", 32'(vld_total - v0), 32'd1);
        chk("t2_code_hold", 32'(key_code), 32'd3);

        // 3: clear, then enter 1..5 with clean releases
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("t3_clr_digits", 32'(digits), 32'd0);
        chk("t3_clr_cnt", 32'(digit_cnt), 32'd0);
        v0 = vld_total;
        for (int k = 1; k <= 5; k++) begin
            d = 10'(1 << k);
            tick(8);
            d = 10'd0;
            tick(8);
        end
        chk("t3_digits", 32'(digits), 32'h2345);
        chk("t3_cnt_sat", 32'(digit_cnt), 32'd4);
        chk("t3_pulses", 32'(vld_total - v0), 32'd5);
        chk("t3_code", 32'(key_code), 32'd5);

        // 4: bouncing key 7, then steady
        v0 = vld_total;
        d = 10'b00_1000_0000;
        tick(2);
        d = 10'd0;
        tick(1);
        d = 10'b00_1000_0000;
        tick(5);
        chk("t4_no_early_pulse", 32'(vld_total - v0), 32'd0);
        chk("t4_edge5_valid", 32'(key_valid), 32'd0);
        tick(1);
        chk("t4_edge6_valid", 32'(key_valid), 32'd1);
        chk("t4_code", 32'(key_code), 32'd7);
        tick(2);
        d = 10'd0;
        tick(10);
        chk("t4_pulses", 32'(vld_total - v0), 32'd1);
        chk("t4_digits", 32'(digits), 32'h3457);

        // 5: keys 2 and 5 together
        v0 = vld_total;
        e0 = err_total;
        d = 10'b00_0010_0100;
        tick(6);
        chk("t5_err", 32'(key_err), 32'd1);
        chk("t5_valid", 32'(key_valid), 32'd0);
        chk("t5_code", 32'(key_code), 32'd7);
        chk("t5_digits", 32'(digits), 32'h3457);
        chk("t5_cnt", 32'(digit_cnt), 32'd4);
        tick(1);
        chk("t5_err_width", 32'(key_err), 32'd0);
        tick(2);
        d = 10'd0;
        tick(10);
        chk("t5_err_pulses", 32'(err_total - e0), 32'd1);
        chk("t5_valid_pulses", 32'(vld_total - v0), 32'd0);

        // 6: clr coincident with key 9 accept, then reset mid-debounce
        d = 10'b10_0000_0000;
        tick(5);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("t6_valid", 32'(key_valid), 32'd1);
        chk("t6_code", 32'(key_code), 32'd9);
        chk("t6_digits", 32'(digits), 32'd0);
        chk("t6_cnt", 32'(digit_cnt), 32'd0);
        tick(2);
        d = 10'd0;
        tick(10);

        v0 = vld_total;
        d = 10'b00_0001_0000;
        tick(4);
        rst = 1'b1;
        d = 10'd0;
        tick(1);
        chk("t6_rst_code", 32'(key_code), 32'd0);
        chk("t6_rst_valid", 32'(key_valid), 32'd0);
        chk("t6_rst_digits", 32'(digits), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(10);
        chk("t6_rst_no_pulse", 32'(vld_total - v0), 32'd0);
        chk("t6_rst_cnt", 32'(digit_cnt), 32'd0);

        chk("never_both", 32'(both_total), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
